if_id_pipe_stage: RTL and testbench

Parametrised IF/ID pipeline stage that carries the fetched instruction and its PC from fetch to decode. It adds a valid/ready handshake and an optional 2-entry skid buffer, so decode can stall without a combinational ready path back into fetch. It also provides a synchronous flush that squashes in-flight instructions on a branch or jump redirect. Bubbles are presented to decode as an explicit NOP.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/if_id_pipe_stage_if.sv | 31 +++
 rtl/pipe_skid_buf.sv | 90 +++++++++
 rtl/if_id_pipe_stage.sv | 51 +++++
 tb/tb_if_id_pipe_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage slice: default widths, NOP encoding,
// stage occupancy states and the {inst, pc} beat payload.
package pipe_pkg;

  localparam int unsigned PIPE_INST_W   = 16;
  localparam int unsigned PIPE_PC_W     = 16;
  localparam logic [PIPE_INST_W-1:0] PIPE_NOP_INST = 16'h0000;

  // Encoding equals occupancy so occ can be taken straight from the state flops
  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } stage_st_e;

  typedef struct packed {
    logic [PIPE_INST_W-1:0] inst;
    logic [PIPE_PC_W-1:0]   pc;
  } pipe_beat_t;

  function automatic logic [1:0] st_occ(input stage_st_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/if_id_pipe_stage_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID stage.
interface if_id_pipe_stage_if
  import pipe_pkg::*;
#(
  parameter int unsigned INST_W = PIPE_INST_W,
  parameter int unsigned PC_W   = PIPE_PC_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst_in;
  logic [PC_W-1:0]   pc_in;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   pc_out;
  logic [1:0]        occ;

  // master: the surrounding pipeline (fetch producer + decode consumer)
  modport master (
    output in_valid, inst_in, pc_in, out_ready,
    input  in_ready, out_valid, inst_out, pc_out, occ
  );

  // slave: the stage itself
  modport slave (
    input  in_valid, inst_in, pc_in, out_ready,
    output in_ready, out_valid, inst_out, pc_out, occ
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register with optional second (skid) entry; the main
// entry drives the outputs and is refilled with idle_data whenever it empties.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned   W        = 32,
  parameter bit            SKID     = 1'b1,
  parameter logic [W-1:0]  RST_DATA = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] idle_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output stage_st_e    st
);

  stage_st_e    st_q;
  logic         main_valid_q;
  logic         rdy_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;

  // With a skid entry ready is a flop, so out_ready never reaches in_ready
  assign in_ready  = SKID ? rdy_q : (!main_valid_q || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid_q && out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign st        = st_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= ST_EMPTY;
      main_valid_q <= 1'b0;
      rdy_q        <= 1'b1;
      main_q       <= RST_DATA;
      skid_q       <= '0;
    end else if (clear) begin
      st_q         <= ST_EMPTY;
      main_valid_q <= 1'b0;
      rdy_q        <= 1'b1;
      main_q       <= idle_data;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q       <= in_data;
            main_valid_q <= 1'b1;
            st_q         <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (SKID && in_xfer) begin
            skid_q <= in_data;
            rdy_q  <= 1'b0;
            st_q   <= ST_SKID_FULL;
          end else if (out_xfer) begin
            main_q       <= idle_data;
            main_valid_q <= 1'b0;
            st_q         <= ST_EMPTY;
          end
        end
        ST_SKID_FULL: begin
          if (out_xfer) begin
            main_q <= skid_q;
            rdy_q  <= 1'b1;
            st_q   <= ST_FULL;
          end
        end
        default: begin
          st_q         <= ST_EMPTY;
          main_valid_q <= 1'b0;
          rdy_q        <= 1'b1;
          main_q       <= idle_data;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: skid-buffered {inst, pc} handshake with synchronous
// flush, registered NOP on bubbles and an occupancy count.
module if_id_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       INST_W   = PIPE_INST_W,
  parameter int unsigned       PC_W     = PIPE_PC_W,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST),
  parameter bit                SKID     = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  input logic                flush,
  if_id_pipe_stage_if.slave  bus
);

  localparam int unsigned BEAT_W = INST_W + PC_W;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat;
  logic [BEAT_W-1:0] idle_beat;
  stage_st_e         st;

  assign in_beat = {bus.inst_in, bus.pc_in};

  // Emptied main entry shows NOP but keeps the PC of the beat it last held
  assign idle_beat = {NOP_INST, out_beat[PC_W-1:0]};

  pipe_skid_buf #(
    .W        (BEAT_W),
    .SKID     (SKID),
    .RST_DATA ({NOP_INST, PC_W'(0)})
  ) u_skid_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush),
    .idle_data (idle_beat),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_beat),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_beat),
    .st        (st)
  );

  assign bus.inst_out = out_beat[BEAT_W-1:PC_W];
  assign bus.pc_out   = out_beat[PC_W-1:0];
  assign bus.occ      = st_occ(st);

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: SKID=1 and SKID=0 instances checked each cycle
// against a queue-based model, plus directed reset/backpressure/flush steps.
module tb_if_id_pipe_stage;
  import pipe_pkg::*;

  localparam int unsigned IW = PIPE_INST_W;
  localparam int unsigned PW = PIPE_PC_W;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  always #5 clk = ~clk;

  if_id_pipe_stage_if #(.INST_W(IW), .PC_W(PW)) bus1 ();
  if_id_pipe_stage_if #(.INST_W(IW), .PC_W(PW)) bus0 ();

  if_id_pipe_stage #(.INST_W(IW), .PC_W(PW), .NOP_INST(16'h0000), .SKID(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus1));
  if_id_pipe_stage #(.INST_W(IW), .PC_W(PW), .NOP_INST(16'h0000), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus0));

  int unsigned total = 0;
  int unsigned bad   = 0;

  // stimulus per instance (index = SKID value)
  logic        iv   [2];
  pipe_beat_t  ib   [2];
  logic        ordy [2];
  // reference model: held beats in order, front = what decode sees
  pipe_beat_t  mq   [2][$];
  logic [15:0] mlast_pc [2];
  logic        mrdy [2];
  logic        macc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int d, output logic v, output logic r,
                         output logic [15:0] i, output logic [15:0] p, output logic [1:0] o);
    if (d == 1) begin
      v = bus1.out_valid; r = bus1.in_ready; i = bus1.inst_out; p = bus1.pc_out; o = bus1.occ;
    end else begin
      v = bus0.out_valid; r = bus0.in_ready; i = bus0.inst_out; p = bus0.pc_out; o = bus0.occ;
    end
  endtask

  task automatic drive();
    bus1.in_valid = iv[1]; bus1.inst_in = ib[1].inst; bus1.pc_in = ib[1].pc; bus1.out_ready = ordy[1];
    bus0.in_valid = iv[0]; bus0.inst_in = ib[0].inst; bus0.pc_in = ib[0].pc; bus0.out_ready = ordy[0];
  endtask

  function automatic logic model_ready(input int d);
    if (d == 1) return mq[1].size() < 2;
    return (mq[0].size() == 0) || ordy[0];
  endfunction

  task automatic check_model();
    logic v, r;
    logic [15:0] i, p;
    logic [1:0] o;
    int n;
    for (int d = 0; d < 2; d++) begin
      get_obs(d, v, r, i, p, o);
      n = mq[d].size();
      chk($sformatf("s%0d_out_valid", d), 32'(v), 32'(n > 0));
      chk($sformatf("s%0d_inst_out", d), 32'(i), (n > 0) ? 32'(mq[d][0].inst) : 32'(16'h0000));
      chk($sformatf("s%0d_pc_out", d), 32'(p), (n > 0) ? 32'(mq[d][0].pc) : 32'(mlast_pc[d]));
      chk($sformatf("s%0d_occ", d), 32'(o), 32'(n));
      chk($sformatf("s%0d_in_ready", d), 32'(r), 32'(model_ready(d)));
      chk($sformatf("s%0d_occ_le2", d), 32'(o <= 2'd2), 32'd1);
    end
  endtask

  // One clock: drive, check pre-edge view, clock, advance the model
  task automatic step();
    logic ox;
    drive();
    #1;
    check_model();
    for (int d = 0; d < 2; d++) mrdy[d] = model_ready(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      macc[d] = iv[d] && mrdy[d];
      ox = (mq[d].size() > 0) && ordy[d];
      if (flush) begin
        mq[d].delete();
      end else begin
        if (ox) void'(mq[d].pop_front());
        if (macc[d]) mq[d].push_back(ib[d]);
      end
      if (mq[d].size() > 0) mlast_pc[d] = mq[d][0].pc;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mlast_pc[d] = 16'h0000;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ib[d] = '0; ordy[d] = 1'b1; macc[d] = 1'b0; mrdy[d] = 1'b1;
    end
    model_reset();
    drive();
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;

    chk("reset_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus1.in_ready), 32'd1);
    step();

    // streaming: one beat per cycle into both instances
    for (int k = 0; k < 10; k++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = 1'b1; ordy[d] = 1'b1;
        ib[d].inst = 16'h1000 + 16'(k); ib[d].pc = 16'(k);
      end
      step();
      chk("stream_s1_inst", 32'(bus1.inst_out), 32'(16'h1000 + 16'(k)));
      chk("stream_s1_pc", 32'(bus1.pc_out), 32'(k));
      chk("stream_s0_inst", 32'(bus0.inst_out), 32'(16'h1000 + 16'(k)));
      chk("stream_s1_in_ready", 32'(bus1.in_ready), 32'd1);
    end
    iv[0] = 1'b0; iv[1] = 1'b0;
    step();
    chk("stream_drained_nop", 32'(bus1.inst_out), 32'h0);
    chk("stream_drained_pc", 32'(bus1.pc_out), 32'd9);

    // backpressure on the skid instance
    ordy[1] = 1'b0; iv[1] = 1'b1; ib[1] = '{inst: 16'hA001, pc: 16'h0020};
    step();
    ib[1] = '{inst: 16'hB002, pc: 16'h0021};
    step();
    chk("bp_occ2", 32'(bus1.occ), 32'd2);
    chk("bp_in_ready_low", 32'(bus1.in_ready), 32'd0);
    chk("bp_head_a", 32'(bus1.inst_out), 32'hA001);
    iv[1] = 1'b0; ordy[1] = 1'b1;
    step();
    chk("bp_then_b", 32'(bus1.inst_out), 32'hB002);
    chk("bp_in_ready_back", 32'(bus1.in_ready), 32'd1);
    step();
    chk("bp_empty", 32'(bus1.out_valid), 32'd0);

    // flush collides with input and output transfers at occ=2
    ordy[1] = 1'b0; iv[1] = 1'b1; ib[1] = '{inst: 16'hD001, pc: 16'h0030};
    step();
    ib[1] = '{inst: 16'hD002, pc: 16'h0031};
    step();
    chk("fl_pre_occ2", 32'(bus1.occ), 32'd2);
    flush = 1'b1; ordy[1] = 1'b1; iv[1] = 1'b1; ib[1] = '{inst: 16'hC003, pc: 16'h0032};
    step();
    flush = 1'b0; iv[1] = 1'b0;
    chk("fl_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("fl_inst_nop", 32'(bus1.inst_out), 32'h0);
    chk("fl_occ0", 32'(bus1.occ), 32'd0);
    step();
    chk("fl_c003_gone", 32'(bus1.out_valid), 32'd0);

    // combinational ready on the single-register instance
    ordy[0] = 1'b0; iv[0] = 1'b1; ib[0] = '{inst: 16'hE001, pc: 16'h0040};
    step();
    ib[0] = '{inst: 16'hF002, pc: 16'h0041};
    drive();
    #1;
    chk("s0_ready_low_same_cycle", 32'(bus0.in_ready), 32'd0);
    ordy[0] = 1'b1;
    drive();
    #1;
    chk("s0_ready_high_same_cycle", 32'(bus0.in_ready), 32'd1);
    step();
    chk("s0_reload_main", 32'(bus0.inst_out), 32'hF002);
    chk("s0_reload_occ", 32'(bus0.occ), 32'd1);
    iv[0] = 1'b0;
    step();

    // asynchronous reset with two beats held
    ordy[1] = 1'b0; iv[1] = 1'b1; ib[1] = '{inst: 16'h7001, pc: 16'h0050};
    step();
    ib[1] = '{inst: 16'h7002, pc: 16'h0051};
    step();
    chk("rst_pre_occ2", 32'(bus1.occ), 32'd2);
    iv[1] = 1'b0; drive();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_inst_nop", 32'(bus1.inst_out), 32'h0);
    chk("rst_pc_zero", 32'(bus1.pc_out), 32'h0);
    chk("rst_occ_zero", 32'(bus1.occ), 32'd0);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    model_reset();
    #1 reset_n = 1'b1;
    step();

    // constrained random with hold-until-accepted upstream
    for (int d = 0; d < 2; d++) iv[d] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      flush = ($urandom_range(0, 24) == 0);
      for (int d = 0; d < 2; d++) begin
        ordy[d] = ($urandom_range(0, 3) != 0);
        if (!iv[d] || macc[d]) begin
          iv[d] = ($urandom_range(0, 3) != 0);
          ib[d].inst = 16'($urandom);
          ib[d].pc   = 16'($urandom);
        end
      end
      for (int d = 0; d < 2; d++) macc[d] = 1'b0;
      step();
    end
    flush = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
